// File: rtl/ped_btn_cond_pkg.sv
// Shared definitions for the pedestrian button conditioner: state encodings,
// default timing constants and the counter-width helper.
package ped_btn_cond_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS_DB = 3'd1,
    S_HOLD     = 3'd2,
    S_WAIT_REL = 3'd3,
    S_REL_DB   = 3'd4
  } btn_state_t;

  localparam int TL_SYS_CLK_HZ      = 50_000_000;
  localparam int TL_DEBOUNCE_MS     = 10;
  localparam int TL_HOLD_MS         = 1500;
  localparam int TL_DEBOUNCE_CYCLES = (TL_SYS_CLK_HZ / 1000) * TL_DEBOUNCE_MS;
  localparam int TL_HOLD_CYCLES     = (TL_SYS_CLK_HZ / 1000) * TL_HOLD_MS;

  // One counter serves both debounce and hold; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser, asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ped_btn_cond.sv
// Pedestrian button conditioner: synchronise, debounce press/release, stretch
// each accepted press into a HOLD_CYCLES request. Option: BTN_ACTIVE_LOW_EN.
//
// state      | meaning
// S_IDLE     | released and armed, waiting for btn_s high
// S_PRESS_DB | debouncing a press
// S_HOLD     | ped_req asserted for HOLD_CYCLES, button ignored
// S_WAIT_REL | hold over, waiting for the button to be released
// S_REL_DB   | debouncing a release
module ped_btn_cond
  import ped_btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = TL_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = TL_HOLD_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  output logic       ped_req,
  output logic       press_pulse,
  output logic [7:0] press_cnt
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic       w_btn_in;
  logic       w_btn_s;
  logic       w_db_done;
  logic       w_hold_done;
  logic       w_accept;
  btn_state_t r_state;
  btn_state_t w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic       r_ped_req;
  logic       r_press_pulse;
  logic [7:0] r_press_cnt;

  // Inverting ahead of the synchroniser keeps flop reset value = released.
`ifdef BTN_ACTIVE_LOW_EN
  assign w_btn_in = ~btn_raw;
`else
  assign w_btn_in = btn_raw;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_btn_in),
    .o_q   (w_btn_s)
  );

  assign w_db_done   = (r_cnt == DB_LAST);
  assign w_hold_done = (r_cnt == HOLD_LAST);

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:     w_state_nxt = w_btn_s ? S_PRESS_DB : S_IDLE;
      S_PRESS_DB: begin
        if (!w_btn_s)       w_state_nxt = S_IDLE;
        else if (w_db_done) w_state_nxt = S_HOLD;
        else                w_state_nxt = S_PRESS_DB;
      end
      S_HOLD:     w_state_nxt = w_hold_done ? S_WAIT_REL : S_HOLD;
      S_WAIT_REL: w_state_nxt = w_btn_s ? S_WAIT_REL : S_REL_DB;
      S_REL_DB: begin
        if (w_btn_s)        w_state_nxt = S_WAIT_REL;
        else if (w_db_done) w_state_nxt = S_IDLE;
        else                w_state_nxt = S_REL_DB;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_PRESS_DB) && (w_state_nxt == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ped_req     <= 1'b0;
      r_press_pulse <= 1'b0;
      r_press_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if ((r_state == S_PRESS_DB) || (r_state == S_HOLD) || (r_state == S_REL_DB))
        r_cnt <= r_cnt + CNT_W'(1);
      r_ped_req     <= (w_state_nxt == S_HOLD);
      r_press_pulse <= w_accept;
      if (w_accept)
        r_press_cnt <= r_press_cnt + 8'd1;
    end
  end

  assign ped_req     = r_ped_req;
  assign press_pulse = r_press_pulse;
  assign press_cnt   = r_press_cnt;

endmodule

// File: tb/tb_ped_btn_cond.sv
// Self-checking bench for ped_btn_cond (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8):
// directed scenarios plus random button traffic against a run-length model.
module tb_ped_btn_cond;

  localparam int D = 4;
  localparam int H = 8;
`ifdef BTN_ACTIVE_LOW_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       btn_raw;
  logic       ped_req;
  logic       press_pulse;
  logic [7:0] press_cnt;

  ped_btn_cond #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .ped_req     (ped_req),
    .press_pulse (press_pulse),
    .press_cnt   (press_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Model: armed -> (D+1 consecutive high samples) -> holding for H cycles ->
  // releasing -> (D+1 consecutive low samples) -> armed.
  localparam int M_ARMED = 0, M_HOLDING = 1, M_RELEASING = 2;
  int   m_mode, m_run, m_hold, m_cnt;
  logic m_s1, m_s2, m_req, m_pulse;

  int obs_pulses, obs_req_cycles, first_req;
  int step_no;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode = M_ARMED; m_run = 0; m_hold = 0; m_cnt = 0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_req = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_edge(input logic p);
    logic s;
    s = m_s2;
    m_pulse = 1'b0;
    case (m_mode)
      M_ARMED: begin
        m_run = s ? m_run + 1 : 0;
        if (m_run == D + 1) begin
          m_mode = M_HOLDING; m_hold = H; m_run = 0;
          m_pulse = 1'b1; m_cnt = (m_cnt + 1) % 256;
        end
      end
      M_HOLDING: begin
        m_hold = m_hold - 1;
        if (m_hold == 0) begin m_mode = M_RELEASING; m_run = 0; end
      end
      default: begin
        m_run = !s ? m_run + 1 : 0;
        if (m_run == D + 1) begin m_mode = M_ARMED; m_run = 0; end
      end
    endcase
    m_req = (m_mode == M_HOLDING);
    m_s2 = m_s1;
    m_s1 = p;
  endtask

  // Starts and ends at a negedge; p is the logical "pressed" level.
  task automatic step(input logic p);
    btn_raw = p ^ POL;
    @(posedge clk);
    model_edge(p);
    #1;
    step_no = step_no + 1;
    chk("ped_req", int'(ped_req), int'(m_req));
    chk("press_pulse", int'(press_pulse), int'(m_pulse));
    chk("press_cnt", int'(press_cnt), m_cnt);
    obs_pulses     = obs_pulses + int'(press_pulse);
    obs_req_cycles = obs_req_cycles + int'(ped_req);
    if (ped_req === 1'b1 && first_req == 0) first_req = step_no;
    @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_pulses = 0; obs_req_cycles = 0; first_req = 0; step_no = 0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    btn_raw = POL;
    model_reset();
    #1;
    chk("rst_ped_req", int'(ped_req), 0);
    chk("rst_press_cnt", int'(press_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic steps(input logic p, input int n);
    for (int i = 0; i < n; i++) step(p);
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = POL;
    model_reset();
    clear_obs();
    @(negedge clk);
    chk("rst_pulse", int'(press_pulse), 0);

    // Clean press
    do_reset();
    clear_obs();
    steps(1'b1, 30);
    chk("clean_latency", first_req, D + 3);
    chk("clean_width", obs_req_cycles, H);
    chk("clean_pulses", obs_pulses, 1);
    chk("clean_cnt", int'(press_cnt), 1);
    steps(1'b0, 10);

    // Bounce: 2-cycle highs never survive debounce
    do_reset();
    clear_obs();
    for (int k = 0; k < 5; k++) begin
      steps(1'b1, 2);
      steps(1'b0, 2);
    end
    steps(1'b0, 10);
    chk("bounce_req", obs_req_cycles, 0);
    chk("bounce_cnt", int'(press_cnt), 0);

    // Hold without release
    do_reset();
    clear_obs();
    steps(1'b1, 100);
    chk("hold_width", obs_req_cycles, H);
    chk("hold_pulses", obs_pulses, 1);
    chk("hold_cnt", int'(press_cnt), 1);
    steps(1'b0, 10);

    // Repeat presses, then a re-press inside S_HOLD that must not count
    do_reset();
    clear_obs();
    for (int k = 0; k < 3; k++) begin
      steps(1'b1, 20);
      steps(1'b0, 20);
    end
    chk("repeat_pulses", obs_pulses, 3);
    chk("repeat_cnt", int'(press_cnt), 3);
    clear_obs();
    steps(1'b1, 8);
    steps(1'b0, 2);
    steps(1'b1, 8);
    steps(1'b0, 20);
    chk("inhold_pulses", obs_pulses, 1);
    chk("inhold_cnt", int'(press_cnt), 4);

    // Reset in the 4th ped_req cycle drops the request without a clock edge
    do_reset();
    clear_obs();
    steps(1'b1, D + 3 + 3);
    chk("pre_rst_req", int'(ped_req), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", int'(ped_req), 0);
    chk("async_rst_cnt", int'(press_cnt), 0);
    btn_raw = POL;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    steps(1'b0, 5);
    clear_obs();
    steps(1'b1, 20);
    chk("post_rst_latency", first_req, D + 3);
    chk("post_rst_cnt", int'(press_cnt), 1);
    steps(1'b0, 10);

    // Wrap after 256 presses
    do_reset();
    clear_obs();
    for (int k = 0; k < 255; k++) begin
      steps(1'b1, 8);
      steps(1'b0, 16);
    end
    chk("cnt_255", int'(press_cnt), 255);
    steps(1'b1, 8);
    steps(1'b0, 16);
    chk("wrap_pulses", obs_pulses, 256);
    chk("wrap_cnt", int'(press_cnt), 0);

    // Random button traffic against the model
    do_reset();
    for (int k = 0; k < 120; k++) begin
      logic lvl;
      lvl = k[0];
      steps(lvl, int'($urandom_range(1, 12)));
    end
    steps(1'b0, 12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
